// File: rtl/alu_regfile_seq_if.sv
// Instruction, status and readback bundle for alu_regfile_seq.
// Combinational wires only. The source holds an instruction until instr_ready is high.
interface alu_regfile_seq_if #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
);
    localparam int RSEL = $clog2(NREG);

    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       opcode;
    logic [RSEL-1:0]  rd;
    logic [RSEL-1:0]  rs;
    logic [WIDTH-1:0] imm;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             carry;
    logic             zero;
    logic [RSEL-1:0]  rb_addr;
    logic [WIDTH-1:0] rb_data;

    modport master (
        output instr_valid, opcode, rd, rs, imm, rb_addr,
        input  instr_ready, done, result, hi, carry, zero, rb_data
    );

    modport slave (
        input  instr_valid, opcode, rd, rs, imm, rb_addr,
        output instr_ready, done, result, hi, carry, zero, rb_data
    );
endinterface

// File: rtl/alu_regfile_seq.sv
// Register file with ALU and shift-add multiplier, one instruction at a time.
// Latency is 1 edge for ALU ops and WIDTH+1 edges for MUL; instr_ready is low while busy.
module alu_regfile_seq #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic              CK,
    input  logic              CLR,
    alu_regfile_seq_if.slave  bus
);
    localparam int RSEL = $clog2(NREG);
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  regs_q [NREG];
    logic [2:0]        op_q;
    logic [RSEL-1:0]   rd_q;
    logic [WIDTH-1:0]  b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  hi_q;
    logic              carry_q;
    logic              zero_q;
    logic              done_q;

    logic [WIDTH-1:0]  a_w;
    logic [WIDTH:0]    alu_d;
    logic [WIDTH:0]    mac_d;

    // Low half of prod_q holds operand A until MUL runs, then the product's low half.
    assign a_w = prod_q[WIDTH-1:0];
    assign mac_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);

    always_comb begin
        alu_d = '0;
        case (op_q)
            3'b000:  alu_d = {1'b0, b_q};
            3'b001:  alu_d = {1'b0, a_w} + {1'b0, b_q};
            3'b010:  alu_d = {1'b0, a_w} - {1'b0, b_q};
            3'b011:  alu_d = {1'b0, a_w};
            3'b100:  alu_d = {1'b0, a_w & b_q};
            3'b101:  alu_d = {1'b0, a_w | b_q};
            3'b110:  alu_d = {1'b0, a_w ^ b_q};
            default: alu_d = {1'b0, a_w};
        endcase
    end

    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= IDLE;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.instr_valid) begin
                        op_q    <= bus.opcode;
                        rd_q    <= bus.rd;
                        b_q     <= bus.imm;
                        prod_q  <= {{WIDTH{1'b0}}, regs_q[bus.rs]};
                        cnt_q   <= CW'(WIDTH);
                        state_q <= (bus.opcode == 3'b011) ? MUL : EXEC;
                    end
                end
                MUL: begin
                    prod_q <= {mac_d, prod_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= WB;
                end
                default: begin
                    regs_q[rd_q] <= alu_d[WIDTH-1:0];
                    result_q     <= alu_d[WIDTH-1:0];
                    carry_q      <= alu_d[WIDTH];
                    zero_q       <= (alu_d[WIDTH-1:0] == '0);
                    if (op_q == 3'b011) hi_q <= prod_q[2*WIDTH-1:WIDTH];
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.hi          = hi_q;
    assign bus.carry       = carry_q;
    assign bus.zero        = zero_q;
    assign bus.rb_data     = regs_q[bus.rb_addr];
endmodule

// File: tb/tb_alu_regfile_seq.sv
// Bench for alu_regfile_seq: 8-bit/4-reg instance with directed and random instructions
// against an arithmetic reference model, plus a 16-bit/8-reg instance with directed cases.
module tb_alu_regfile_seq;
    logic CK;
    logic CLR;
    int   n_chk  = 0;
    int   n_fail = 0;

    int mregs [4];
    int mres, mhi, mcarry, mzero;

    alu_regfile_seq_if #(.WIDTH(8),  .NREG(4)) ifa ();
    alu_regfile_seq_if #(.WIDTH(16), .NREG(8)) ifb ();

    alu_regfile_seq #(.WIDTH(8),  .NREG(4)) dut  (.CK(CK), .CLR(CLR), .bus(ifa));
    alu_regfile_seq #(.WIDTH(16), .NREG(8)) dut2 (.CK(CK), .CLR(CLR), .bus(ifb));

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        mres = 0; mhi = 0; mcarry = 0; mzero = 0;
    endtask

    task automatic model_apply(input int op, input int rd, input int rs, input int imm);
        int a;
        int r;
        int c;
        a = mregs[rs];
        c = 0;
        case (op)
            0: r = imm;
            1: begin r = a + imm; c = (r > 255) ? 1 : 0; end
            2: begin r = a - imm; c = (a < imm) ? 1 : 0; end
            3: begin r = a * imm; mhi = r / 256; end
            4: r = a & imm;
            5: r = a | imm;
            6: r = a ^ imm;
            default: r = a;
        endcase
        r = r & 255;
        mregs[rd] = r;
        mres = r;
        mcarry = c;
        mzero = (r == 0) ? 1 : 0;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            ifa.rb_addr = 2'(i);
            #1;
            chk({tag, "_rb"}, ifa.rb_data, mregs[i]);
        end
        chk({tag, "_result"}, ifa.result, mres);
        chk({tag, "_hi"}, ifa.hi, mhi);
        chk({tag, "_carry"}, ifa.carry, mcarry);
        chk({tag, "_zero"}, ifa.zero, mzero);
    endtask

    task automatic drive(input int op, input int rd, input int rs, input int imm);
        ifa.opcode      = 3'(op);
        ifa.rd          = 2'(rd);
        ifa.rs          = 2'(rs);
        ifa.imm         = 8'(imm);
        ifa.instr_valid = 1'b1;
    endtask

    // Called on the negedge just after the accept edge; returns at the negedge that shows done.
    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        int rdy_bad = 0;
        while (n < 60) begin
            @(posedge CK);
            n++;
            @(negedge CK);
            if (ifa.done) break;
            if (ifa.instr_ready) rdy_bad++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_rdy"}, rdy_bad, 0);
        chk({tag, "_rdy_after"}, ifa.instr_ready, 1'b1);
    endtask

    task automatic issue(input string tag, input int op, input int rd, input int rs, input int imm);
        drive(op, rd, rs, imm);
        chk({tag, "_rdy_pre"}, ifa.instr_ready, 1'b1);
        @(posedge CK);
        @(negedge CK);
        ifa.instr_valid = 1'b0;
        chk({tag, "_rdy_low"}, ifa.instr_ready, 1'b0);
        chk({tag, "_done_low"}, ifa.done, 1'b0);
        if (op == 3) begin
            ifa.rb_addr = 2'(rd);
            #1;
            chk({tag, "_rd_old"}, ifa.rb_data, mregs[rd]);
        end
        wait_done(tag, (op == 3) ? 9 : 1);
        model_apply(op, rd, rs, imm);
        check_state(tag);
    endtask

    task automatic issue2(input string tag, input int op, input int rd, input int rs, input int imm,
                          input int exp_lat);
        int n = 0;
        ifb.opcode      = 3'(op);
        ifb.rd          = 3'(rd);
        ifb.rs          = 3'(rs);
        ifb.imm         = 16'(imm);
        ifb.instr_valid = 1'b1;
        @(posedge CK);
        @(negedge CK);
        ifb.instr_valid = 1'b0;
        while (n < 60) begin
            @(posedge CK);
            n++;
            @(negedge CK);
            if (ifb.done) break;
        end
        chk({tag, "_latency"}, n, exp_lat);
    endtask

    initial begin
        int op, rd, rs, imm, pulses;
        ifa.instr_valid = 1'b0; ifa.opcode = '0; ifa.rd = '0; ifa.rs = '0; ifa.imm = '0; ifa.rb_addr = '0;
        ifb.instr_valid = 1'b0; ifb.opcode = '0; ifb.rd = '0; ifb.rs = '0; ifb.imm = '0; ifb.rb_addr = '0;
        CLR = 1'b0;
        model_reset();
        repeat (2) @(posedge CK);
        @(negedge CK);
        chk("rst_ready", ifa.instr_ready, 1'b1);
        chk("rst_done", ifa.done, 1'b0);
        check_state("rst");
        CLR = 1'b1;

        issue("ldi_r1", 0, 1, 0, 8'h05);
        issue("ldi_r0", 0, 0, 0, 8'hFF);
        issue("add_wrap", 1, 2, 0, 8'h01);
        issue("sub_borrow", 2, 3, 2, 8'h01);
        issue("ldi_r1_ff", 0, 1, 0, 8'hFF);
        issue("mul_ff", 3, 1, 1, 8'hFF);

        // MUL with instr_valid held and fields changed to an ADD while busy.
        drive(3, 2, 3, 8'h03);
        chk("hold_rdy_pre", ifa.instr_ready, 1'b1);
        @(posedge CK);
        @(negedge CK);
        drive(1, 0, 2, 8'h10);
        wait_done("hold_mul", 9);
        model_apply(3, 2, 3, 8'h03);
        check_state("hold_mul");
        @(posedge CK);
        @(negedge CK);
        ifa.instr_valid = 1'b0;
        chk("hold_add_rdy_low", ifa.instr_ready, 1'b0);
        wait_done("hold_add", 1);
        model_apply(1, 0, 2, 8'h10);
        check_state("hold_add");

        for (int k = 0; k < 40; k++) begin
            op  = int'($urandom_range(0, 7));
            rd  = int'($urandom_range(0, 3));
            rs  = int'($urandom_range(0, 3));
            imm = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
            if (op == 2 && $urandom_range(0, 3) == 0) imm = mregs[rs];
            issue("rand", op, rd, rs, imm);
        end

        // Reset in the middle of a MUL.
        issue("abort_ldi", 0, 1, 0, 8'h12);
        drive(3, 2, 1, 8'h34);
        @(posedge CK);
        @(negedge CK);
        ifa.instr_valid = 1'b0;
        repeat (3) @(posedge CK);
        #2;
        CLR = 1'b0;
        #1;
        model_reset();
        chk("abort_rdy", ifa.instr_ready, 1'b1);
        chk("abort_done", ifa.done, 1'b0);
        check_state("abort");
        @(posedge CK);
        @(negedge CK);
        CLR = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CK);
            @(negedge CK);
            if (ifa.done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        check_state("post_abort");

        // 16-bit, 8-register instance.
        issue2("w16_ldi7", 0, 7, 0, 16'h00F0, 1);
        issue2("w16_ldi6", 0, 6, 0, 16'h1234, 1);
        issue2("w16_xor", 6, 7, 7, 16'hFFFF, 1);
        chk("w16_xor_result", ifb.result, 16'hFF0F);
        chk("w16_xor_carry", ifb.carry, 1'b0);
        chk("w16_xor_zero", ifb.zero, 1'b0);
        ifb.rb_addr = 3'd7;
        #1;
        chk("w16_rb7", ifb.rb_data, 16'hFF0F);
        ifb.rb_addr = 3'd6;
        #1;
        chk("w16_rb6", ifb.rb_data, 16'h1234);
        issue2("w16_mul", 3, 5, 7, 16'h0101, 17);
        chk("w16_mul_lo", ifb.result, 16'h0E0F);
        chk("w16_mul_hi", ifb.hi, 16'h0100);
        issue2("w16_add", 1, 4, 7, 16'h00F1, 1);
        chk("w16_add_result", ifb.result, 16'h0000);
        chk("w16_add_carry", ifb.carry, 1'b1);
        chk("w16_add_zero", ifb.zero, 1'b1);
        chk("w16_hi_kept", ifb.hi, 16'h0100);
        @(posedge CK);
        @(negedge CK);
        chk("w16_done_width", ifb.done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_regfile_seq.md
# alu_regfile_seq

Parametrised successor to the three-register add/multiply datapath. It holds NREG registers of WIDTH bits and executes one instruction at a time over a valid/ready handshake. Each instruction has a source register, an immediate operand, a destination register and a 3-bit opcode. Multiply is a sequential shift-add unit, and every operation updates carry/zero flags. The block sits between the front-panel instruction source (DIP word) and the display/readback logic.

## Interface
- WIDTH, 8, datapath and register width (≥2)
- NREG, 4, number of registers (power of 2, ≥2)
- RSEL, log2(NREG), register-select width (derived, not overridden)
- CK  in  1  clock, rising edge
- CLR  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present on opcode/rd/rs/imm
- instr_ready  out  1  block can accept; high only in IDLE
- opcode  in  3  operation select
- rd  in  RSEL  destination register
- rs  in  RSEL  source register
- imm  in  WIDTH  immediate operand (DIP input)
- done  out  1  one-cycle pulse on the writeback edge
- result  out  WIDTH  last value written back; held until the next writeback
- hi  out  WIDTH  upper half of the last MUL product; unchanged by other ops
- carry  out  1  carry/borrow flag
- zero  out  1  set when the last written result == 0
- rb_addr  in  RSEL  readback select
- rb_data  out  WIDTH  combinational readback of reg[rb_addr]

## Operation
- Accept: at a CK edge with instr_valid && instr_ready, latch opcode, rd, imm and A = reg[rs] into internal registers. rs == rd is legal because the operand is captured at accept.
- Opcodes (B = imm):
  - 000 LDI: rd ← B
  - 001 ADD: rd ← A+B; carry = bit WIDTH of the sum
  - 010 SUB: rd ← A−B; carry = borrow (A<B unsigned)
  - 011 MUL: {hi, rd} ← A×B, unsigned, 2·WIDTH-bit product
  - 100 AND, 101 OR, 110 XOR: rd ← A op B; carry ← 0
  - 111 MOV: rd ← A; carry ← 0
- zero is updated on every writeback. hi is written only by MUL.
- FSM:
  - IDLE → EXEC on accept for opcode ≠ 011.
  - IDLE → MUL on accept for opcode 011; the iteration counter is loaded with WIDTH.
  - EXEC → IDLE at the next edge: writeback, done = 1.
  - MUL: each edge adds B (shifted) into the accumulator when the current multiplier bit is set, shifts, and decrements the counter. When the counter reaches 0 → WB.
  - WB → IDLE: writeback, done = 1.
- instr_valid outside IDLE is ignored. Instructions are not queued, and the source must hold them until instr_ready.
- rb_data reflects register contents after the most recent edge. The destination shows its old value until the writeback edge.

## Timing
- Reset, asynchronous while CLR = 0: all registers 0, state IDLE, instr_ready 1, done 0, result 0, hi 0, carry 0, zero 0.
- CLR asserted mid-MUL or mid-EXEC aborts the instruction: no writeback and no done pulse.
- Non-MUL latency: accept at edge k, writeback and done at edge k+1, instr_ready high again after edge k+1. The next instruction can be accepted at edge k+2.
- MUL latency: accept at edge k, writeback at edge k+WIDTH+1, done high for the cycle after that edge.
- instr_ready falls combinationally with the state change after the accept edge. done is exactly 1 cycle wide.
- Arithmetic is modulo 2^WIDTH. Overflow is visible only through carry (ADD/SUB) and hi (MUL).

## Test plan
- Reset, then LDI r1 ← 0x05, then readback rb_addr = 1 → rb_data = 0x05, done one pulse at edge 2, zero = 0.
- WIDTH = 8: r0 = 0xFF, ADD rd = r2, rs = r0, imm = 0x01 → r2 = 0x00, carry = 1, zero = 1. Then SUB r3 ← r2 − 0x01 → 0xFF, carry = 1.
- MUL r1 = 0xFF, imm = 0xFF, rd = r1 → r1 = 0x01, hi = 0xFE, done exactly 9 edges after accept, instr_ready low throughout.
- instr_valid held high during a MUL with a different opcode: only the first instruction executes, and the second is accepted on the first edge with instr_ready = 1.
- CLR pulsed low 3 edges into a MUL with r1 = 0x12 preloaded → all registers 0, no done pulse, instr_ready = 1 immediately.
- WIDTH = 16, NREG = 8: XOR r7 ← r7 ^ 0xFFFF starting from r7 = 0x00F0 → r7 = 0xFF0F, carry = 0, readback r6 unchanged.
